receiving_fsm: RTL and testbench

- Reassembles 16-bit words from the byte stream delivered by the UART receiver (PC -> CPU direction).
- Counterpart of the transmit path, which sends the high byte first, then the low byte.
- Presents completed words to the I/O hub through a one-entry valid/ready output buffer.
- Provides inter-byte timeout resynchronisation and overflow/error reporting.

---
 rtl/receiving_fsm_if.sv | 31 +++
 rtl/receiving_fsm.sv | 108 ++++++++++
 tb/tb_receiving_fsm.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/receiving_fsm_if.sv
// Byte-in / word-out bundle between the UART receiver, the word assembler and the I/O hub.
// The cs_err_o flag exists only when RX_CHECKSUM_EN is defined.
interface receiving_fsm_if;
  logic [7:0]  rx_byte_i;
  logic        rx_valid_i;
  logic [15:0] word_o;
  logic        word_valid_o;
  logic        word_ready_i;
  logic        overflow_o;
  logic        timeout_o;
  logic        clr_err_i;
`ifdef RX_CHECKSUM_EN
  logic        cs_err_o;
`endif

  modport slave (
    input  rx_byte_i, rx_valid_i, word_ready_i, clr_err_i,
    output word_o, word_valid_o, overflow_o, timeout_o
`ifdef RX_CHECKSUM_EN
    , output cs_err_o
`endif
  );

  modport master (
    output rx_byte_i, rx_valid_i, word_ready_i, clr_err_i,
    input  word_o, word_valid_o, overflow_o, timeout_o
`ifdef RX_CHECKSUM_EN
    , input cs_err_o
`endif
  );
endinterface

// File: rtl/receiving_fsm.sv
// Reassembles {high, low} 16-bit words from UART bytes into a one-entry valid/ready buffer.
// RX_CHECKSUM_EN adds a trailing hi^lo checksum byte per word and the cs_err_o flag.
module receiving_fsm #(
  parameter int TIMEOUT = 50000,
  parameter int TO_W    = 16
) (
  input  logic          clk_i,
  input  logic          rst_i,
  receiving_fsm_if.slave bus
);
`ifdef RX_CHECKSUM_EN
  typedef enum logic [1:0] {WAIT_H = 2'd0, WAIT_L = 2'd1, WAIT_CS = 2'd2} state_t;
`else
  typedef enum logic {WAIT_H = 1'b0, WAIT_L = 1'b1} state_t;
`endif

  localparam logic [TO_W-1:0] TO_LAST = (TIMEOUT == 0) ? '0 : TO_W'(TIMEOUT - 1);

  state_t          state;
  logic [7:0]      hi_reg;
  logic [TO_W-1:0] to_cnt;
  logic [15:0]     word_q;
  logic            vld_q, ovf_q, to_q;
  logic            commit, drop, to_evt;
  logic [15:0]     new_word;
`ifdef RX_CHECKSUM_EN
  logic [7:0]      lo_reg;
  logic            cs_q, cs_bad;
`endif

  always_comb begin
    // A byte arriving in the expiry cycle suppresses the timeout.
    to_evt = (TIMEOUT != 0) && (state != WAIT_H) && !bus.rx_valid_i && (to_cnt == TO_LAST);
`ifdef RX_CHECKSUM_EN
    new_word = {hi_reg, lo_reg};
    commit   = (state == WAIT_CS) && bus.rx_valid_i && (bus.rx_byte_i == (hi_reg ^ lo_reg));
    cs_bad   = (state == WAIT_CS) && bus.rx_valid_i && (bus.rx_byte_i != (hi_reg ^ lo_reg));
`else
    new_word = {hi_reg, bus.rx_byte_i};
    commit   = (state == WAIT_L) && bus.rx_valid_i;
`endif
    drop = commit && vld_q && !bus.word_ready_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state  <= WAIT_H;
      hi_reg <= '0;
      to_cnt <= '0;
      word_q <= '0;
      vld_q  <= 1'b0;
      ovf_q  <= 1'b0;
      to_q   <= 1'b0;
`ifdef RX_CHECKSUM_EN
      lo_reg <= '0;
      cs_q   <= 1'b0;
`endif
    end else begin
      case (state)
        WAIT_H:
          if (bus.rx_valid_i) begin
            hi_reg <= bus.rx_byte_i;
            to_cnt <= '0;
            state  <= WAIT_L;
          end
        WAIT_L:
          if (bus.rx_valid_i) begin
`ifdef RX_CHECKSUM_EN
            lo_reg <= bus.rx_byte_i;
            to_cnt <= '0;
            state  <= WAIT_CS;
`else
            state  <= WAIT_H;
`endif
          end else if (to_evt) state <= WAIT_H;
          else                 to_cnt <= to_cnt + 1'b1;
`ifdef RX_CHECKSUM_EN
        WAIT_CS:
          if (bus.rx_valid_i || to_evt) state <= WAIT_H;
          else                          to_cnt <= to_cnt + 1'b1;
`endif
        default: state <= WAIT_H;
      endcase

      // A commit with a simultaneous consume replaces the buffered word in place.
      if (commit && !drop) begin
        word_q <= new_word;
        vld_q  <= 1'b1;
      end else if (vld_q && bus.word_ready_i) begin
        vld_q  <= 1'b0;
      end

      ovf_q <= (ovf_q && !bus.clr_err_i) || drop;
      to_q  <= (to_q  && !bus.clr_err_i) || to_evt;
`ifdef RX_CHECKSUM_EN
      cs_q  <= (cs_q  && !bus.clr_err_i) || cs_bad;
`endif
    end
  end

  assign bus.word_o       = word_q;
  assign bus.word_valid_o = vld_q;
  assign bus.overflow_o   = ovf_q;
  assign bus.timeout_o    = to_q;
`ifdef RX_CHECKSUM_EN
  assign bus.cs_err_o     = cs_q;
`endif
endmodule

// File: tb/tb_receiving_fsm.sv
// Self-checking bench: byte-queue reference model compared every cycle plus literal expectations.
module tb_receiving_fsm;
  localparam int TMO = 16;
`ifdef RX_CHECKSUM_EN
  localparam int FRAME = 3;
`else
  localparam int FRAME = 2;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cmp_en = 1'b0;
  logic rnd = 1'b0;
  int   checks = 0;
  int   failures = 0;

  receiving_fsm_if bif ();
  receiving_fsm #(.TIMEOUT(TMO), .TO_W(16)) dut (.clk_i(clk), .rst_i(rst), .bus(bif));

  always #5 clk = ~clk;

  // Reference model: collect bytes in a queue, count idle cycles since the last byte.
  logic [7:0]  mq[$];
  int          idle;
  logic [15:0] m_word;
  logic        m_vld, m_ovf, m_to, m_cs;

  always @(posedge clk) begin : model
    logic com, sto, sov, scs;
    logic [15:0] nw;
    if (rst) begin
      mq.delete(); idle = 0;
      m_word = 16'h0; m_vld = 1'b0; m_ovf = 1'b0; m_to = 1'b0; m_cs = 1'b0;
    end else begin
      com = 1'b0; sto = 1'b0; sov = 1'b0; scs = 1'b0; nw = 16'h0;
      if (bif.rx_valid_i) begin
        mq.push_back(bif.rx_byte_i);
        idle = 0;
        if (mq.size() == FRAME) begin
          if (FRAME == 3 && mq[2] != (mq[0] ^ mq[1])) scs = 1'b1;
          else begin com = 1'b1; nw = {mq[0], mq[1]}; end
          mq.delete();
        end
      end else if (mq.size() != 0) begin
        idle++;
        if (idle == TMO) begin mq.delete(); sto = 1'b1; end
      end
      if (com) begin
        if (!m_vld || bif.word_ready_i) begin m_word = nw; m_vld = 1'b1; end
        else sov = 1'b1;
      end else if (m_vld && bif.word_ready_i) m_vld = 1'b0;
      if (bif.clr_err_i) begin m_ovf = 1'b0; m_to = 1'b0; m_cs = 1'b0; end
      m_ovf = m_ovf | sov;
      m_to  = m_to  | sto;
      m_cs  = m_cs  | scs;
    end
  end

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: actual=%h expected=%h", nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && cmp_en) begin
      chk("model_valid", {15'h0, bif.word_valid_o}, {15'h0, m_vld});
      chk("model_overflow", {15'h0, bif.overflow_o}, {15'h0, m_ovf});
      chk("model_timeout", {15'h0, bif.timeout_o}, {15'h0, m_to});
`ifdef RX_CHECKSUM_EN
      chk("model_cs_err", {15'h0, bif.cs_err_o}, {15'h0, m_cs});
`endif
      if (m_vld) chk("model_word", bif.word_o, m_word);
    end
  end

  task automatic step();
    if (rnd) begin
      bif.word_ready_i = ($urandom % 2) == 1;
      bif.clr_err_i    = ($urandom % 50) == 0;
    end
    @(negedge clk);
  endtask

  task automatic idle_n(input int n);
    repeat (n) step();
  endtask

  task automatic send_byte(input logic [7:0] b);
    bif.rx_valid_i = 1'b1;
    bif.rx_byte_i  = b;
    step();
    bif.rx_valid_i = 1'b0;
    bif.rx_byte_i  = 8'($urandom);
  endtask

  // Sends one framed word; word_ready_i takes rdy only during the final byte.
  task automatic send_word(input logic [7:0] hi, input logic [7:0] lo, input logic rdy);
    logic r;
    r = bif.word_ready_i;
    send_byte(hi);
`ifdef RX_CHECKSUM_EN
    send_byte(lo);
    bif.word_ready_i = rdy;
    send_byte(hi ^ lo);
`else
    bif.word_ready_i = rdy;
    send_byte(lo);
`endif
    bif.word_ready_i = r;
  endtask

  task automatic consume();
    bif.word_ready_i = 1'b1;
    step();
    bif.word_ready_i = 1'b0;
  endtask

  task automatic clr_pulse();
    bif.clr_err_i = 1'b1;
    step();
    bif.clr_err_i = 1'b0;
  endtask

  // Tail of a word whose first byte was already sent, without touching word_ready_i.
  task automatic finish_word(input logic [7:0] hi, input logic [7:0] lo);
    send_byte(lo);
`ifdef RX_CHECKSUM_EN
    send_byte(hi ^ lo);
`endif
  endtask

  initial begin
    bif.rx_byte_i = 8'h0; bif.rx_valid_i = 1'b0;
    bif.word_ready_i = 1'b0; bif.clr_err_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_valid", {15'h0, bif.word_valid_o}, 16'h0);
    chk("reset_word", bif.word_o, 16'h0);
    chk("reset_overflow", {15'h0, bif.overflow_o}, 16'h0);
    chk("reset_timeout", {15'h0, bif.timeout_o}, 16'h0);
    rst = 1'b0;
    cmp_en = 1'b1;
    @(negedge clk);

    // Basic word, consumer ready.
    bif.word_ready_i = 1'b1;
    send_word(8'hA5, 8'h3C, 1'b1);
    chk("basic_valid", {15'h0, bif.word_valid_o}, 16'h1);
    chk("basic_word", bif.word_o, 16'hA53C);
    step();
    chk("basic_pulse_end", {15'h0, bif.word_valid_o}, 16'h0);
    chk("basic_no_flags", {14'h0, bif.overflow_o, bif.timeout_o}, 16'h0);
    bif.word_ready_i = 1'b0;

    // Overflow: second word dropped, first held.
    send_word(8'h12, 8'h34, 1'b0);
    send_word(8'h56, 8'h78, 1'b0);
    chk("ovf_word_held", bif.word_o, 16'h1234);
    chk("ovf_valid", {15'h0, bif.word_valid_o}, 16'h1);
    chk("ovf_flag", {15'h0, bif.overflow_o}, 16'h1);
    clr_pulse();
    chk("ovf_cleared", {15'h0, bif.overflow_o}, 16'h0);
    consume();
    chk("ovf_consumed", {15'h0, bif.word_valid_o}, 16'h0);

    // Timeout discards the stray high byte.
    send_byte(8'hFF);
    idle_n(20);
    chk("to_flag", {15'h0, bif.timeout_o}, 16'h1);
    send_word(8'h01, 8'h02, 1'b0);
    chk("to_resync_word", bif.word_o, 16'h0102);
    consume();
    clr_pulse();
    chk("to_cleared", {15'h0, bif.timeout_o}, 16'h0);

    // Low byte at cycle 15 after the high byte, then at cycle 16 (coincides with expiry).
    send_byte(8'hAB);
    idle_n(14);
    finish_word(8'hAB, 8'hCD);
    chk("to_edge15_word", bif.word_o, 16'hABCD);
    chk("to_edge15_no_to", {15'h0, bif.timeout_o}, 16'h0);
    consume();
    send_byte(8'h5A);
    idle_n(15);
    send_byte(8'hC3);
`ifdef RX_CHECKSUM_EN
    send_byte(8'h5A ^ 8'hC3);
`endif
    chk("to_edge16_word", bif.word_o, 16'h5AC3);
    chk("to_edge16_no_to", {15'h0, bif.timeout_o}, 16'h0);
    consume();

    // Buffer full, completion coincides with consume.
    send_word(8'h11, 8'h11, 1'b0);
    send_word(8'h22, 8'h22, 1'b1);
    chk("replace_word", bif.word_o, 16'h2222);
    chk("replace_valid", {15'h0, bif.word_valid_o}, 16'h1);
    chk("replace_no_ovf", {15'h0, bif.overflow_o}, 16'h0);
    consume();

`ifdef RX_CHECKSUM_EN
    send_byte(8'h12); send_byte(8'h34); send_byte(8'h26);
    chk("cs_good_word", bif.word_o, 16'h1234);
    chk("cs_good_valid", {15'h0, bif.word_valid_o}, 16'h1);
    consume();
    send_byte(8'h12); send_byte(8'h34); send_byte(8'h00);
    chk("cs_bad_no_commit", {15'h0, bif.word_valid_o}, 16'h0);
    chk("cs_bad_flag", {15'h0, bif.cs_err_o}, 16'h1);
    clr_pulse();
    chk("cs_cleared", {15'h0, bif.cs_err_o}, 16'h0);
`endif

    // Reset mid-word with a buffered word.
    send_word(8'h09, 8'h09, 1'b0);
    send_byte(8'h77);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_valid", {15'h0, bif.word_valid_o}, 16'h0);
    rst = 1'b0;
    send_word(8'h01, 8'h02, 1'b0);
    chk("midrst_word", bif.word_o, 16'h0102);
    consume();

    // Randomized framing with gaps, corrupt checksums, random ready and clears.
    rnd = 1'b1;
    for (int f = 0; f < 400; f++) begin
      logic [7:0] h, l, c;
      h = 8'($urandom); l = 8'($urandom);
      c = (($urandom % 4) == 0) ? 8'($urandom) : (h ^ l);
      idle_n(($urandom % 10 == 0) ? 17 : int'($urandom % 3));
      send_byte(h);
      idle_n(($urandom % 12 == 0) ? TMO : int'($urandom % 4));
      send_byte(l);
`ifdef RX_CHECKSUM_EN
      idle_n(($urandom % 12 == 0) ? TMO + 1 : int'($urandom % 4));
      send_byte(c);
`else
      if (c == 8'h00) idle_n(1);
`endif
    end
    rnd = 1'b0;
    bif.clr_err_i = 1'b0;
    idle_n(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
